// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master side) and the data memory (slave side).
interface mem_access_unit_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: validates the EX/MEM access, runs one bus transaction with a
// timeout, stalls the pipeline meanwhile and returns the lane-selected, extended load data.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  stall,
    output logic                  err,
    mem_access_unit_if.master     mem
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op, legal, misaligned, accept, reject, timeout_hit;
    logic [2:0]         op_f3;
    logic [1:0]         op_lo;
    logic               op_load;

    function automatic logic [3:0] byte_en(input logic we, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << lo;
                2'b01:   be = 4'b0011 << {lo[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] d,
                                                      input logic [2:0] f3);
        logic [DATA_W-1:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] lo);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(DATA_W-8){b[7]}}, b};
            3'b100:  r = {{(DATA_W-8){1'b0}}, b};
            3'b001:  r = {{(DATA_W-16){h[15]}}, h};
            3'b101:  r = {{(DATA_W-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        op         = MemRead | MemWrite;
        legal      = 1'b0;
        misaligned = 1'b0;
        if (MemRead && !MemWrite) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                 legal = 1'b0;
            endcase
        end else if (MemWrite && !MemRead) begin
            case (func3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end
        if (func3[1:0] == 2'b01)
            misaligned = addr[0];
        else if (func3[1:0] == 2'b10)
            misaligned = (addr[1:0] != 2'b00);
    end

    // The cycle in which the counter would step to TIMEOUT_CYC is the last BUSY cycle,
    // so BUSY lasts at most TIMEOUT_CYC cycles; a mem_ready in that cycle still wins.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (op) begin
                    if (legal && !misaligned) begin
                        accept    = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem.mem_ready || timeout_hit)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall       = !reset && (accept || (state == BUSY));
    assign mem.mem_req = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            ReadData      <= '0;
            err           <= 1'b0;
            op_f3         <= '0;
            op_lo         <= '0;
            op_load       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt           <= '0;
                        mem.mem_we    <= MemWrite;
                        mem.mem_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
                        mem.mem_wdata <= store_lanes(wr_data, func3);
                        mem.mem_be    <= byte_en(MemWrite, func3, addr[1:0]);
                        op_f3         <= func3;
                        op_lo         <= addr[1:0];
                        op_load       <= MemRead;
                    end else if (reject) begin
                        err      <= 1'b1;
                        ReadData <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem.mem_ready) begin
                        ReadData <= op_load ? load_fmt(mem.mem_rdata, op_f3, op_lo) : '0;
                    end else if (timeout_hit) begin
                        ReadData <= '0;
                        err      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load results queued at issue, popped at DONE.
module tb_mem_access_unit;
    localparam int DATA_W      = 32;
    localparam int DM_ADDRESS  = 9;
    localparam int TIMEOUT_CYC = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic [31:0] ReadData;
    logic        stall, err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    mem_access_unit_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) bus ();

    mem_access_unit #(
        .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
        .wr_data(wr_data), .func3(func3), .ReadData(ReadData), .stall(stall), .err(err),
        .mem(bus)
    );

    always #5 clk = ~clk;

    // Drives one access and acts as the memory: mem_ready rises in BUSY cycle ready_at
    // (-1 = never). Reports counts over the access plus two trailing idle cycles.
    task automatic access(
        input  logic        rd, input logic wr, input logic [8:0] a, input logic [31:0] wd,
        input  logic [2:0]  f3, input logic [31:0] rdata, input int ready_at,
        output int          n_stall, output int n_req, output int n_err,
        output logic [31:0] rd_out, output logic we_o, output logic [8:0] addr_o,
        output logic [31:0] wdata_o, output logic [3:0] be_o, output bit unstable
    );
        int busy_idx;
        bit fin, accepted;
        n_stall = 0; n_req = 0; n_err = 0; busy_idx = 0; fin = 0; accepted = 0; unstable = 0;
        rd_out = 'x; we_o = 'x; addr_o = 'x; wdata_o = 'x; be_o = 'x;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3;
        bus.mem_rdata = rdata; bus.mem_ready = 1'b0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            bus.mem_ready = bus.mem_req && (busy_idx == ready_at);
            @(negedge clk);
            if (stall) n_stall++;
            if (err) n_err++;
            if (bus.mem_req) begin
                n_req++;
                if (busy_idx == 0) begin
                    we_o = bus.mem_we; addr_o = bus.mem_addr;
                    wdata_o = bus.mem_wdata; be_o = bus.mem_be;
                end else if (bus.mem_we !== we_o || bus.mem_addr !== addr_o ||
                             bus.mem_wdata !== wdata_o || bus.mem_be !== be_o) begin
                    unstable = 1;
                end
                busy_idx++;
            end
            if (!stall) begin
                fin = 1;
                accepted = (cyc > 0);
                if (accepted) rd_out = ReadData;
            end
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        if (stall) n_stall++;
        if (err) n_err++;
        if (bus.mem_req) n_req++;
        if (!accepted) rd_out = ReadData;
        @(posedge clk); #1;
        @(negedge clk);
        if (stall) n_stall++;
        if (err) n_err++;
        if (bus.mem_req) n_req++;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h000; func3 = 3'b010;
        wr_data = 32'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if ({bus.mem_we, bus.mem_be} !== 5'b0) $display("FAIL reset_we_be: got %b expected 00000", {bus.mem_we, bus.mem_be}); else n_pass++;
        n_checks++; if (bus.mem_addr !== 9'h0) $display("FAIL reset_mem_addr: got %h expected 000", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else n_pass++;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL reset_ReadData: got %h expected 0", ReadData); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0;
    endtask

    task automatic test_loads();
        logic [8:0]  a_t[5];
        logic [2:0]  f_t[5];
        logic [31:0] d_t[5], e_t[5];
        int          r_t[5];
        int ns, nr, ne; logic [31:0] got, mw, expv; logic we; logic [8:0] ma; logic [3:0] be; bit unst;
        a_t = '{9'h005, 9'h007, 9'h002, 9'h000, 9'h00C};
        f_t = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        d_t = '{32'h1234_80FF, 32'h9ABC_DEF0, 32'h8001_7FFF, 32'hFFFF_8765, 32'hDEAD_BEEF};
        e_t = '{32'hFFFF_FF80, 32'h0000_009A, 32'hFFFF_8001, 32'h0000_8765, 32'hDEAD_BEEF};
        r_t = '{0, 1, 0, 2, 3};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(e_t[i]);
            access(1'b1, 1'b0, a_t[i], 32'h0, f_t[i], d_t[i], r_t[i], ns, nr, ne, got, we, ma, mw, be, unst);
            expv = exp_q.pop_front();
            n_checks++; if (got !== expv) $display("FAIL load%0d ReadData: got %h expected %h", i, got, expv); else n_pass++;
            n_checks++; if (ns != 2 + r_t[i]) $display("FAIL load%0d stall_cycles: got %0d expected %0d", i, ns, 2 + r_t[i]); else n_pass++;
            n_checks++; if (ne != 0) $display("FAIL load%0d err_pulses: got %0d expected 0", i, ne); else n_pass++;
            n_checks++; if (ma !== (a_t[i] & 9'h1FC)) $display("FAIL load%0d mem_addr: got %h expected %h", i, ma, a_t[i] & 9'h1FC); else n_pass++;
            n_checks++; if ({we, be} !== 5'b01111) $display("FAIL load%0d we_be: got %b expected 01111", i, {we, be}); else n_pass++;
            n_checks++; if (unst) $display("FAIL load%0d bus_stable: got unstable expected stable", i); else n_pass++;
        end
    endtask

    task automatic test_stores();
        logic [8:0]  a_t[4];
        logic [2:0]  f_t[4];
        logic [31:0] d_t[4], w_t[4];
        logic [3:0]  b_t[4];
        int ns, nr, ne; logic [31:0] got, mw, expv; logic we; logic [8:0] ma; logic [3:0] be; bit unst;
        a_t = '{9'h00A, 9'h003, 9'h1FC, 9'h001};
        f_t = '{3'b001, 3'b000, 3'b010, 3'b000};
        d_t = '{32'h0000_BEEF, 32'h1234_56A5, 32'hCAFE_F00D, 32'h0000_0042};
        w_t = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h4242_4242};
        b_t = '{4'b1100, 4'b1000, 4'b1111, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            access(1'b0, 1'b1, a_t[i], d_t[i], f_t[i], 32'hFFFF_FFFF, 0, ns, nr, ne, got, we, ma, mw, be, unst);
            expv = exp_q.pop_front();
            n_checks++; if (got !== expv) $display("FAIL store%0d ReadData: got %h expected %h", i, got, expv); else n_pass++;
            n_checks++; if ({we, be} !== {1'b1, b_t[i]}) $display("FAIL store%0d we_be: got %b expected %b", i, {we, be}, {1'b1, b_t[i]}); else n_pass++;
            n_checks++; if (mw !== w_t[i]) $display("FAIL store%0d mem_wdata: got %h expected %h", i, mw, w_t[i]); else n_pass++;
            n_checks++; if (ma !== (a_t[i] & 9'h1FC)) $display("FAIL store%0d mem_addr: got %h expected %h", i, ma, a_t[i] & 9'h1FC); else n_pass++;
            n_checks++; if (ns != 2 || nr != 1) $display("FAIL store%0d stall_req: got %0d/%0d expected 2/1", i, ns, nr); else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic        rd_t[6], wr_t[6];
        logic [8:0]  a_t[6];
        logic [2:0]  f_t[6];
        int ns, nr, ne; logic [31:0] got, mw, expv; logic we; logic [8:0] ma; logic [3:0] be; bit unst;
        rd_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wr_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        a_t  = '{9'h006, 9'h001, 9'h00E, 9'h000, 9'h000, 9'h000};
        f_t  = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
        for (int i = 0; i < 6; i++) begin
            // a good load first so the rejected access has a nonzero ReadData to clear
            exp_q.push_back(32'h0BAD_0000 | 32'(i));
            access(1'b1, 1'b0, 9'h040, 32'h0, 3'b010, 32'h0BAD_0000 | 32'(i), 0, ns, nr, ne, got, we, ma, mw, be, unst);
            expv = exp_q.pop_front();
            n_checks++; if (got !== expv) $display("FAIL err%0d pre_load: got %h expected %h", i, got, expv); else n_pass++;
            exp_q.push_back(32'h0);
            access(rd_t[i], wr_t[i], a_t[i], 32'h1111_1111, f_t[i], 32'h2222_2222, 0, ns, nr, ne, got, we, ma, mw, be, unst);
            expv = exp_q.pop_front();
            n_checks++; if (got !== expv) $display("FAIL err%0d ReadData: got %h expected %h", i, got, expv); else n_pass++;
            n_checks++; if (nr != 0) $display("FAIL err%0d mem_req_cycles: got %0d expected 0", i, nr); else n_pass++;
            n_checks++; if (ns != 0) $display("FAIL err%0d stall_cycles: got %0d expected 0", i, ns); else n_pass++;
            n_checks++; if (ne != 1) $display("FAIL err%0d err_pulses: got %0d expected 1", i, ne); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int ns, nr, ne; logic [31:0] got, mw, expv; logic we; logic [8:0] ma; logic [3:0] be; bit unst;
        exp_q.push_back(32'h7E57_0001);
        access(1'b1, 1'b0, 9'h040, 32'h0, 3'b010, 32'h7E57_0001, 0, ns, nr, ne, got, we, ma, mw, be, unst);
        expv = exp_q.pop_front();
        n_checks++; if (got !== expv) $display("FAIL timeout pre_load: got %h expected %h", got, expv); else n_pass++;
        exp_q.push_back(32'h0);
        access(1'b1, 1'b0, 9'h002, 32'h0, 3'b101, 32'hFFFF_FFFF, -1, ns, nr, ne, got, we, ma, mw, be, unst);
        expv = exp_q.pop_front();
        n_checks++; if (got !== expv) $display("FAIL timeout ReadData: got %h expected %h", got, expv); else n_pass++;
        n_checks++; if (ns != TIMEOUT_CYC + 1) $display("FAIL timeout stall_cycles: got %0d expected %0d", ns, TIMEOUT_CYC + 1); else n_pass++;
        n_checks++; if (nr != TIMEOUT_CYC) $display("FAIL timeout mem_req_cycles: got %0d expected %0d", nr, TIMEOUT_CYC); else n_pass++;
        n_checks++; if (ne != 1) $display("FAIL timeout err_pulses: got %0d expected 1", ne); else n_pass++;
        n_checks++; if (unst) $display("FAIL timeout bus_stable: got unstable expected stable"); else n_pass++;
    endtask

    task automatic test_ready_at_limit();
        int ns, nr, ne; logic [31:0] got, mw, expv; logic we; logic [8:0] ma; logic [3:0] be; bit unst;
        exp_q.push_back(32'h5555_AAAA);
        access(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h5555_AAAA, TIMEOUT_CYC - 1, ns, nr, ne, got, we, ma, mw, be, unst);
        expv = exp_q.pop_front();
        n_checks++; if (got !== expv) $display("FAIL limit ReadData: got %h expected %h", got, expv); else n_pass++;
        n_checks++; if (ne != 0) $display("FAIL limit err_pulses: got %0d expected 0", ne); else n_pass++;
        n_checks++; if (ns != TIMEOUT_CYC + 1) $display("FAIL limit stall_cycles: got %0d expected %0d", ns, TIMEOUT_CYC + 1); else n_pass++;
    endtask

    task automatic test_ready_idle();
        @(posedge clk); #1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ReadData !== 32'h5555_AAAA) $display("FAIL idle_ready ReadData: got %h expected 5555aaaa", ReadData); else n_pass++;
        n_checks++; if ({bus.mem_req, stall, err} !== 3'b000) $display("FAIL idle_ready req_stall_err: got %b expected 000", {bus.mem_req, stall, err}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bursts = 0, gap = 0, gap_min = 1000, busy_idx = 0, issued = 0;
        bit prev_req = 0, done_now;
        logic [31:0] expv;
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 9'h010;
        exp_q.push_back(32'hA000_0010); issued = 1;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            bus.mem_rdata = 32'hA000_0000 | 32'(bus.mem_addr);
            bus.mem_ready = bus.mem_req && (busy_idx == 2);
            @(negedge clk);
            done_now = 0;
            if (bus.mem_req) begin
                if (!prev_req) begin
                    bursts++;
                    if (bursts > 1 && gap < gap_min) gap_min = gap;
                end
                busy_idx++; gap = 0;
            end else begin
                gap++;
            end
            if (!stall && prev_req) begin
                expv = exp_q.pop_front();
                n_checks++; if (ReadData !== expv) $display("FAIL b2b ReadData: got %h expected %h", ReadData, expv); else n_pass++;
                busy_idx = 0; done_now = 1;
            end
            prev_req = bus.mem_req;
            @(posedge clk); #1;
            if (done_now) begin
                if (issued == 1) begin
                    addr = 9'h014; exp_q.push_back(32'hA000_0014); issued = 2;
                end else begin
                    MemRead = 1'b0;
                end
            end
        end
        MemRead = 1'b0; bus.mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) bursts++;
            prev_req = bus.mem_req;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b completion: got %0d pending expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (bursts != 2) $display("FAIL b2b bursts: got %0d expected 2", bursts); else n_pass++;
        n_checks++; if (gap_min < 1) $display("FAIL b2b gap: got %0d expected >=1", gap_min); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_in_busy();
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 9'h030;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h7777_1111;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_busy stall_in_reset: got %b expected 0", stall); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_busy mem_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL rst_busy ReadData: got %h expected 0", ReadData); else n_pass++;
        n_checks++; if ({stall, err} !== 2'b00) $display("FAIL rst_busy stall_err: got %b expected 00", {stall, err}); else n_pass++;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.mem_req, err} !== 2'b00 || ReadData !== 32'h0) $display("FAIL rst_busy after: got req/err %b ReadData %h expected 00/0", {bus.mem_req, err}, ReadData); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_ready_at_limit();
        test_ready_idle();
        test_back_to_back();
        test_reset_in_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: DATA_W, default 32, data width. DM_ADDRESS, default 9, byte-address width. TIMEOUT_CYC, default 15, maximum BUSY cycles before abort.
REQ-002 Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  EX/MEM load request.
- MemWrite  in  1  EX/MEM store request.
- addr  in  DM_ADDRESS  byte address.
- wr_data  in  DATA_W  store data.
- func3  in  3  access size/sign.
- ReadData  out  DATA_W  formatted load result.
- stall  out  1  freeze IF/ID/EX/MEM and PC.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write strobe.
- mem_addr  out  DM_ADDRESS  word-aligned address ({addr[DM_ADDRESS-1:2],2'b00}).
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  memory completion.
- mem_rdata  in  DATA_W  raw word.
- err  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, BUSY, DONE. IDLE -> BUSY on an accepted op; BUSY -> DONE on mem_ready or timeout; DONE -> IDLE unconditionally after 1 cycle.
REQ-005 Op present = MemRead|MemWrite; MemRead and MemWrite both high is illegal.
REQ-006 Legal func3 for load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal func3 for store: 000, 001, 010. Any other func3 is illegal.
REQ-007 Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
REQ-008 IDLE with an op that is illegal or misaligned: no memory request; err=1 on the next cycle; ReadData=0; stall stays 0; FSM stays in IDLE.
REQ-009 IDLE with a legal, aligned op: stall=1 combinationally in the same cycle. At the clock edge, register mem_we, mem_addr, mem_wdata and mem_be, and enter BUSY.
REQ-010 mem_req=1 exactly while in BUSY; all mem_* outputs stay stable while mem_req=1.
REQ-011 stall=1 throughout BUSY; stall=0 in DONE and during reset.
REQ-012 Byte enables:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- Loads: 4'b1111 with mem_we=0.
REQ-013 mem_wdata: SB = byte replicated x4; SH = half replicated x2; SW = wr_data unchanged.
REQ-014 BUSY with mem_ready=1: for loads, capture mem_rdata into ReadData, selecting the lane by addr[1:0] and extending per func3; for stores, ReadData=0. Then enter DONE.
REQ-015 A BUSY cycle counter starts at 0 on entry. If the counter reaches TIMEOUT_CYC without mem_ready, abort: ReadData=0, err pulse, enter DONE.
REQ-016 mem_ready in the same cycle the counter reaches TIMEOUT_CYC counts as success; no err.
REQ-017 ReadData holds its value from DONE until the next capture, abort, error or reset.
REQ-018 DONE never starts a request, so the held EX/MEM op is not reissued; the next op is evaluated in IDLE on the following cycle.
REQ-019 mem_ready outside BUSY is ignored.
REQ-020 Latency: op first seen at cycle 0, mem_ready at cycle k≥1, DONE at cycle k+1 with stall=0 and ReadData valid. Minimum stall is 2 cycles.

Reset
REQ-021 Reset values: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadData=0, err=0, stall=0.
REQ-022 Reset asserted in BUSY: mem_req=0 from the next edge; the pending mem_ready is ignored; no err.

Verification
REQ-023 LB at addr=0x005, mem_rdata=0x1234_80FF, mem_ready one cycle after mem_req -> mem_addr=0x004, ReadData=0xFFFF_FF80, stall high exactly 2 cycles.
REQ-024 SH at addr=0x00A, wr_data=0x0000_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x008.
REQ-025 LW at addr=0x006 -> no mem_req, err pulse 1 cycle, stall never asserted, ReadData=0.
REQ-026 LHU at addr=0x002, mem_ready held low -> stall high for TIMEOUT_CYC+1 cycles, then err=1, ReadData=0, FSM in IDLE 2 cycles after abort.
REQ-027 Two back-to-back LW (0x010, then 0x014; mem_ready after 3 cycles) -> exactly two mem_req bursts, separated by at least one non-BUSY cycle.
REQ-028 Reset asserted in BUSY, with mem_ready pulsed on the next cycle -> mem_req=0, ReadData=0, err=0, stall=0 after the reset edge.
